max_reduce_pipe: RTL

//  Parametrised, fully pipelined max-reduction engine for Smith-Waterman score streams.

---
 rtl/max_reduce_pipe.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/max_reduce_pipe.sv
// -----------------------------------------------------------------------------
// max_reduce_pipe
//   Fully pipelined max-reduction engine for Smith-Waterman score streams.
//   Each accepted beat carries N_LANES signed scores. Negative scores are
//   floored to 0. A registered binary comparator tree reduces each beat to
//   (value, lane). A per-packet accumulator keeps the running maximum and its
//   (beat, lane). One result is emitted per packet. Input is never stalled.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous reset, active low
//   clr        in   synchronous clear of in-flight beats and the open packet
//   in_valid   in   beat present on in_data/in_last
//   in_last    in   final beat of the packet (qualified by in_valid)
//   in_data    in   lane k = in_data[DATA_WIDTH*(k+1)-1 : DATA_WIDTH*k]
//   out_valid  out  one-cycle pulse, result fields valid
//   out_max    out  packet maximum (never negative)
//   out_beat   out  0-based beat number of the maximum
//   out_lane   out  lane of the maximum
//   busy       out  a beat is in the tree or a packet is open
//
// Handshake: there is no ready. A beat is accepted on every rising edge where
//   in_valid=1 and clr=0. out_valid is a single-cycle pulse with no
//   backpressure; out_max/out_beat/out_lane hold until the next pulse.
//
// Timing: accept at edge c, tree output valid after edge c+L, accumulator
//   updated at edge c+L+1, out_valid high after edge c+L+2 (L = LANE_W).
// -----------------------------------------------------------------------------
module max_reduce_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int N_LANES    = 64,
  parameter int LANE_W     = 6,
  parameter int BEAT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic                          in_last,
  input  logic [DATA_WIDTH*N_LANES-1:0] in_data,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_max,
  output logic [BEAT_W-1:0]             out_beat,
  output logic [LANE_W-1:0]             out_lane,
  output logic                          busy
);

  localparam int L = LANE_W;

  // Tree storage uses heap numbering: node 1 is the root, node i has children
  // 2i and 2i+1, and leaves N_LANES..2*N_LANES-1 are the stage-0 registers
  // (leaf N_LANES+k holds lane k). Leaf lane indices are implicit constants.
  logic [DATA_WIDTH-1:0] val_d  [1:2*N_LANES-1];
  logic [DATA_WIDTH-1:0] val_q  [1:2*N_LANES-1];
  logic [LANE_W-1:0]     lane_d [1:N_LANES-1];
  logic [LANE_W-1:0]     lane_q [1:N_LANES-1];

  // Per-stage side-band: index 0 is the stage-0 register, index L the tree output.
  logic [L:0]        pv_q;
  logic [L:0]        plast_q;
  logic [BEAT_W-1:0] pbeat_q [0:L];

  logic [BEAT_W-1:0] beat_cnt_d, beat_cnt_q;

  logic                  acc_open_q;
  logic [DATA_WIDTH-1:0] acc_val_q;
  logic [BEAT_W-1:0]     acc_beat_q;
  logic [LANE_W-1:0]     acc_lane_q;
  logic                  emit_q;

  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_max_q;
  logic [BEAT_W-1:0]     out_beat_q;
  logic [LANE_W-1:0]     out_lane_q;

  logic accept;
  assign accept = in_valid & ~clr;

  // Leaves: floor negative lanes to 0.
  for (genvar k = 0; k < N_LANES; k++) begin : g_leaf
    logic [DATA_WIDTH-1:0] raw;
    assign raw                = in_data[DATA_WIDTH*k +: DATA_WIDTH];
    assign val_d[N_LANES + k] = raw[DATA_WIDTH-1] ? '0 : raw;
  end

  // 2:1 compare nodes. Child 2i always covers lower lanes than child 2i+1,
  // so letting 2i+1 win only on strictly greater resolves ties to the lower lane.
  for (genvar i = 1; i < N_LANES; i++) begin : g_node
    logic [DATA_WIDTH-1:0] a_v, b_v;
    logic [LANE_W-1:0]     a_l, b_l;
    logic                  b_win;
    assign a_v = val_q[2*i];
    assign b_v = val_q[2*i+1];
    if (2*i >= N_LANES) begin : g_from_leaf
      assign a_l = LANE_W'(2*i - N_LANES);
      assign b_l = LANE_W'(2*i + 1 - N_LANES);
    end else begin : g_from_node
      assign a_l = lane_q[2*i];
      assign b_l = lane_q[2*i+1];
    end
    assign b_win     = (b_v > a_v);
    assign val_d[i]  = b_win ? b_v : a_v;
    assign lane_d[i] = b_win ? b_l : a_l;
  end

  // Tree data registers are free-running; validity travels in pv_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 2*N_LANES; i++) val_q[i]  <= '0;
      for (int i = 1; i < N_LANES; i++)   lane_q[i] <= '0;
    end else begin
      val_q  <= val_d;
      lane_q <= lane_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q    <= '0;
      plast_q <= '0;
      for (int j = 0; j <= L; j++) pbeat_q[j] <= '0;
    end else begin
      pv_q       <= clr ? '0 : {pv_q[L-1:0], in_valid};
      plast_q    <= {plast_q[L-1:0], in_last};
      pbeat_q[0] <= beat_cnt_q;
      for (int j = 1; j <= L; j++) pbeat_q[j] <= pbeat_q[j-1];
    end
  end

  // Beat counter: tags the entering beat; saturates instead of wrapping, so it
  // is nonzero exactly while a packet is open.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clr) begin
      beat_cnt_d = '0;
    end else if (in_valid) begin
      if (in_last)                beat_cnt_d = '0;
      else if (beat_cnt_q != '1)  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beat_cnt_q <= '0;
    else        beat_cnt_q <= beat_cnt_d;
  end

  // Accumulator. Strictly-greater replacement keeps the earlier beat on a tie.
  logic tree_v, tree_last, take;
  assign tree_v    = pv_q[L];
  assign tree_last = plast_q[L];
  assign take      = ~acc_open_q | (val_q[1] > acc_val_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_open_q <= 1'b0;
      acc_val_q  <= '0;
      acc_beat_q <= '0;
      acc_lane_q <= '0;
      emit_q     <= 1'b0;
    end else if (clr) begin
      acc_open_q <= 1'b0;
      acc_val_q  <= '0;
      acc_beat_q <= '0;
      acc_lane_q <= '0;
      emit_q     <= 1'b0;
    end else begin
      emit_q <= tree_v & tree_last;
      if (tree_v) begin
        if (take) begin
          acc_val_q  <= val_q[1];
          acc_beat_q <= pbeat_q[L];
          acc_lane_q <= lane_q[1];
        end
        acc_open_q <= ~tree_last;
      end
    end
  end

  // Output registers ignore clr so that an already-pending pulse completes.
  // A following packet may overwrite acc on the same edge; the old value is
  // what gets captured here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_max_q   <= '0;
      out_beat_q  <= '0;
      out_lane_q  <= '0;
    end else begin
      out_valid_q <= emit_q;
      if (emit_q) begin
        out_max_q  <= acc_val_q;
        out_beat_q <= acc_beat_q;
        out_lane_q <= acc_lane_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_max   = out_max_q;
  assign out_beat  = out_beat_q;
  assign out_lane  = out_lane_q;
  assign busy      = (|pv_q) | (beat_cnt_q != '0);

endmodule
